// File: rtl/pipeline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_mem_arbiter
// Description : Shares one unified memory port between the Fetch stage and
//               the Memory stage. Data accesses have priority, and a
//               starvation counter guarantees fetch progress. A watchdog
//               aborts accesses the memory never acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset,
  // Fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  // Data side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_mem,
  // Memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int WC_W = $clog2(TIMEOUT);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              err_q, err_d;

  // Abort when the last allowed wait cycle passes without mem_ready;
  // a simultaneous mem_ready takes precedence.
  logic              timeout_w;
  logic [DATA_W-1:0] rdata_sel_w;
  assign timeout_w   = ~mem_ready & (wait_cnt_q == WAIT_LAST);
  assign rdata_sel_w = mem_ready ? mem_rdata : '0;

  // Register all state; asynchronous clear abandons any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      err_q        <= err_d;
    end
  end

  // Arbitration, access tracking and completion handling.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        // While a valid pulse is out, the requester still shows the request
        // just served; arbitration waits one turnaround cycle.
        if (!(if_valid_q || d_valid_q)) begin
          if (d_req && !(if_req && (starve_cnt_q == STARVE_MAX))) begin
            state_d     = ST_DATA;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            wait_cnt_d  = '0;
            if (if_req) begin
              if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + SC_W'(1);
              end
            end else begin
              starve_cnt_d = '0;
            end
          end else if (if_req) begin
            state_d      = ST_FETCH;
            mem_req_d    = 1'b1;
            mem_we_d     = 1'b0;
            mem_addr_d   = if_addr;
            mem_wdata_d  = '0;
            wait_cnt_d   = '0;
            starve_cnt_d = '0;
          end
        end
      end

      ST_DATA, ST_FETCH: begin
        if (mem_ready || timeout_w) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          wait_cnt_d = '0;
          if (timeout_w) begin
            err_d = 1'b1;
          end
          // A withdrawn (flushed) request gets neither a pulse nor new data.
          if (state_q == ST_DATA) begin
            if (d_req) begin
              d_valid_d = 1'b1;
              if (!mem_we_q) begin
                d_rdata_d = rdata_sel_w;
              end
            end
          end else if (if_req) begin
            if_valid_d = 1'b1;
            if_rdata_d = rdata_sel_w;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign err       = err_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_req & ~d_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_mem_arbiter
// Description : Self-checking bench for pipeline_mem_arbiter: directed
//               scenarios plus randomized traffic against a transaction-level
//               reference model and a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;

  logic        clk, reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_valid, stall_if, d_valid, stall_mem, mem_req, mem_we, err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  pipeline_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_fail;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding access, transaction-level bookkeeping
  int          t, free_at, mwait, lat, starve, force_lat;
  bit          busy, bside, bwe;
  bit          exp_mem_req, exp_if_valid, exp_d_valid, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_if_rdata, exp_d_rdata;
  bit          fix_rd_en, noise_en;
  logic [31:0] fix_rd;
  bit          grants[$];

  task automatic model_reset();
    busy = 0; bside = 0; bwe = 0; mwait = 0; lat = 0; starve = 0; free_at = 0;
    exp_mem_req = 0; exp_if_valid = 0; exp_d_valid = 0; exp_err = 0;
    exp_addr = 0; exp_wdata = 0; exp_if_rdata = 0; exp_d_rdata = 0;
  endtask

  // Predict the outputs of the next cycle from this cycle's inputs.
  task automatic model_update();
    bit          rq, tmo, pick_d;
    logic [31:0] rd;
    exp_if_valid = 0;
    exp_d_valid  = 0;
    if (busy) begin
      tmo = !mem_ready && (mwait == TIMEOUT - 1);
      if (mem_ready || tmo) begin
        rq = bside ? d_req : if_req;
        rd = mem_ready ? mem_rdata : 32'h0;
        busy = 0;
        exp_mem_req = 0;
        if (tmo) exp_err = 1;
        if (rq) begin
          if (bside) begin
            exp_d_valid = 1;
            if (!bwe) exp_d_rdata = rd;
          end else begin
            exp_if_valid = 1;
            exp_if_rdata = rd;
          end
          free_at = t + 2;
        end else begin
          free_at = t + 1;
        end
      end else begin
        mwait++;
      end
    end else if (t >= free_at && (if_req || d_req)) begin
      pick_d = d_req && !(if_req && starve == STARVE_LIMIT);
      if (pick_d) starve = if_req ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
      else        starve = 0;
      busy  = 1;
      bside = pick_d;
      bwe   = pick_d ? d_we : 1'b0;
      mwait = 0;
      if (force_lat >= 0) lat = force_lat;
      else lat = ($urandom_range(19) == 0) ? 100 : int'($urandom_range(3));
      exp_mem_req = 1;
      exp_addr    = pick_d ? d_addr : if_addr;
      exp_wdata   = d_wdata;
      grants.push_back(pick_d);
    end
  endtask

  // One clock cycle: memory response, stall checks, model step, output checks.
  task automatic cycle();
    if (busy) mem_ready = (mwait == lat);
    else      mem_ready = noise_en ? 1'($urandom_range(1)) : 1'b0;
    mem_rdata = fix_rd_en ? fix_rd : $urandom;
    #1;
    chk_eq("stall_if", 32'(stall_if), 32'(if_req & ~exp_if_valid));
    chk_eq("stall_mem", 32'(stall_mem), 32'(d_req & ~exp_d_valid));
    model_update();
    @(posedge clk);
    #1;
    t++;
    chk_eq("mem_req", 32'(mem_req), 32'(exp_mem_req));
    if (exp_mem_req) begin
      chk_eq("mem_addr", mem_addr, exp_addr);
      chk_eq("mem_we", 32'(mem_we), 32'(bwe));
      if (bside) chk_eq("mem_wdata", mem_wdata, exp_wdata);
    end
    chk_eq("if_valid", 32'(if_valid), 32'(exp_if_valid));
    chk_eq("d_valid", 32'(d_valid), 32'(exp_d_valid));
    chk_eq("if_rdata", if_rdata, exp_if_rdata);
    chk_eq("d_rdata", d_rdata, exp_d_rdata);
    chk_eq("err", 32'(err), 32'(exp_err));
  endtask

  // Requesters: start a new request with probability p when idle or served.
  task automatic drive_reqs(input int p);
    if (!d_req || exp_d_valid) begin
      if (int'($urandom_range(99)) < p) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(1));
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
      end else begin
        d_req = 1'b0;
      end
    end
    if (!if_req || exp_if_valid) begin
      if (int'($urandom_range(99)) < p) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else begin
        if_req = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((busy || d_req || if_req) && cnt < 200) begin
      drive_reqs(0);
      cycle();
      cnt++;
    end
    chk_eq("drain_done", 32'(busy || d_req || if_req), 32'd0);
    cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk_eq({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk_eq({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk_eq({tag, "_d_valid"}, 32'(d_valid), 32'd0);
    chk_eq({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk_eq({tag, "_d_rdata"}, d_rdata, 32'd0);
    chk_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    n_checks = 0; n_fail = 0; t = 0;
    force_lat = 0; fix_rd_en = 0; fix_rd = 0; noise_en = 0;
    reset = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
    d_addr = 0; d_wdata = 0; mem_ready = 0; mem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("por");
    reset = 1'b1;
    cycle();
    cycle();

    // Single zero-wait load
    fix_rd_en = 1; fix_rd = 32'hDEADBEEF; force_lat = 0;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    cycle();
    chk_eq("ld_mem_req_c1", 32'(mem_req), 32'd1);
    cycle();
    chk_eq("ld_mem_req_c2", 32'(mem_req), 32'd0);
    chk_eq("ld_valid_c2", 32'(d_valid), 32'd1);
    chk_eq("ld_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 0;
    cycle();
    chk_eq("ld_valid_c3", 32'(d_valid), 32'd0);
    cycle();

    // Store with three wait states
    d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'h12345678; force_lat = 3;
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk_eq("st_mem_req", 32'(mem_req), 32'd1);
      chk_eq("st_mem_we", 32'(mem_we), 32'd1);
      chk_eq("st_mem_wdata", mem_wdata, 32'h12345678);
      cycle();
    end
    chk_eq("st_valid", 32'(d_valid), 32'd1);
    chk_eq("st_rdata_kept", d_rdata, 32'hDEADBEEF);
    d_req = 0; d_we = 0;
    cycle();

    // Fetch that the memory never acknowledges
    if_req = 1; if_addr = 32'h200; force_lat = 1000;
    cycle();
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      cycle();
    end
    chk_eq("tmo_len", 32'(cnt), 32'd16);
    chk_eq("tmo_if_valid", 32'(if_valid), 32'd1);
    chk_eq("tmo_if_rdata", if_rdata, 32'd0);
    chk_eq("tmo_err", 32'(err), 32'd1);
    if_req = 0;
    cycle();
    if_req = 1; if_addr = 32'h204; force_lat = 1; fix_rd = 32'hCAFEF00D;
    cycle(); cycle(); cycle();
    chk_eq("post_tmo_valid", 32'(if_valid), 32'd1);
    chk_eq("post_tmo_rdata", if_rdata, 32'hCAFEF00D);
    chk_eq("post_tmo_err", 32'(err), 32'd1);
    if_req = 0;
    cycle();

    // Fetch flushed while waiting
    if_req = 1; if_addr = 32'h300; force_lat = 3; fix_rd = 32'h55AA55AA;
    cycle(); cycle();
    if_req = 0;
    cycle(); cycle(); cycle();
    chk_eq("flush_no_valid", 32'(if_valid), 32'd0);
    chk_eq("flush_rdata_kept", if_rdata, 32'hCAFEF00D);
    chk_eq("flush_mem_req", 32'(mem_req), 32'd0);
    cycle();

    // Reset in the second wait cycle of a load
    d_req = 1; d_we = 0; d_addr = 32'h400; force_lat = 5;
    cycle(); cycle();
    chk_eq("rst_pre_mem_req", 32'(mem_req), 32'd1);
    d_req = 0;
    #2;
    reset = 1'b0;
    #1;
    chk_zero("rst");
    model_reset();
    mem_ready = 0;
    @(posedge clk);
    #1;
    t++;
    reset = 1'b1;
    d_req = 1; d_addr = 32'h404; force_lat = 1; fix_rd = 32'h0BADF00D;
    cycle(); cycle(); cycle();
    chk_eq("post_rst_valid", 32'(d_valid), 32'd1);
    chk_eq("post_rst_rdata", d_rdata, 32'h0BADF00D);
    d_req = 0;
    cycle();

    // Anti-starvation: both sides request continuously, two wait states
    fix_rd_en = 0; force_lat = 2;
    grants.delete();
    cnt = 0;
    while (grants.size() < 10 && cnt < 200) begin
      drive_reqs(100);
      cycle();
      cnt++;
    end
    chk_eq("starve_grant_count", 32'(grants.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk_eq($sformatf("starve_grant%0d_is_data", i), 32'(grants[i]), 32'((i % 5 == 4) ? 0 : 1));
    drain();

    // Randomized traffic with random latency, occasional timeouts and
    // mem_ready noise outside accesses
    force_lat = -1; noise_en = 1;
    for (int i = 0; i < 1500; i++) begin
      drive_reqs(30);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
